// File: rtl/psk_symbol_framer.sv
// BPSK preamble + payload serializer feeding the PSK modulator symbol FIFO.
// Optional payload scrambler (x^7+x^4+1, seed 7'h7F) enabled by PSK_FRAMER_SCRAMBLE_EN.
//
// state | meaning
// IDLE  | waiting for in_tvalid to start a frame
// PRE   | sending preamble symbols, MSB first, tuser=1
// LOAD  | in_tready=1, waiting for the next payload byte
// PAY   | serializing the held byte, 8 (BPSK) or 4 (QPSK) symbols
module psk_symbol_framer #(
    parameter int          PAYLOAD_BYTES = 8,
    parameter int          PREAMBLE_BITS = 16,
    parameter logic [31:0] PREAMBLE      = 32'h0000_E2B4
) (
    input  logic       clk_16M384,
    input  logic       rst_16M384,
    input  logic       cfg_is_bpsk,
    input  logic [7:0] in_tdata,
    input  logic       in_tvalid,
    output logic       in_tready,
    output logic [7:0] sym_tdata,
    output logic       sym_tvalid,
    input  logic       sym_tready,
    output logic       sym_tlast,
    output logic       sym_tuser,
    output logic       frame_busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;
    localparam logic [1:0] ST_PAY  = 2'd3;

    // Preamble left-aligned so bit 31 is always the first symbol sent.
    localparam logic [31:0] PRE_ALIGNED = 32'(PREAMBLE << (32 - PREAMBLE_BITS));
    localparam logic [4:0]  PRE_LAST    = 5'(PREAMBLE_BITS - 1);
    localparam logic [7:0]  LAST_BYTE   = 8'(PAYLOAD_BYTES);

    logic [1:0] state;
    logic       mode;
    logic [4:0] pre_cnt;
    logic [7:0] byte_cnt;
    logic [2:0] sym_cnt;
    logic [7:0] shreg;

    logic       handshake;
    logic       pay_present;
    logic       final_byte;
    logic [2:0] last_idx;
    logic [2:0] next_idx;
    logic [1:0] ks;
    logic [1:0] pay_bits;

    assign handshake  = sym_tvalid && sym_tready;
    assign in_tready  = (state == ST_LOAD);
    assign frame_busy = (state != ST_IDLE);
    assign last_idx   = mode ? 3'd7 : 3'd3;
    assign next_idx   = sym_tvalid ? sym_cnt + 3'd1 : 3'd0;
    assign final_byte = (byte_cnt == LAST_BYTE);
    // First symbol of a byte is presented on PAY entry; later ones on each handshake.
    assign pay_present = (state == ST_PAY) &&
                         (!sym_tvalid || (handshake && sym_cnt != last_idx));

`ifdef PSK_FRAMER_SCRAMBLE_EN
    logic [6:0] lfsr;
    logic [6:0] lfsr_1;
    logic [6:0] lfsr_2;

    always_comb begin
        lfsr_1 = {lfsr[5:0], lfsr[6] ^ lfsr[3]};
        lfsr_2 = {lfsr_1[5:0], lfsr_1[6] ^ lfsr_1[3]};
        ks     = {lfsr[6], lfsr_1[6]};
    end

    always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
        if (rst_16M384) begin
            lfsr <= 7'h7F;
        end else if (state == ST_IDLE && in_tvalid) begin
            lfsr <= 7'h7F;
        end else if (pay_present) begin
            lfsr <= mode ? lfsr_1 : lfsr_2;
        end
    end
`else
    assign ks = 2'b00;
`endif

    always_comb begin
        pay_bits = 2'b00;
        if (mode) begin
            pay_bits = {shreg[7] ^ ks[1], 1'b0};
        end else begin
            pay_bits = {shreg[7] ^ ks[1], shreg[6] ^ ks[0]};
        end
    end

    always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
        if (rst_16M384) begin
            state      <= ST_IDLE;
            mode       <= 1'b0;
            pre_cnt    <= 5'd0;
            byte_cnt   <= 8'd0;
            sym_cnt    <= 3'd0;
            shreg      <= 8'd0;
            sym_tvalid <= 1'b0;
            sym_tdata  <= 8'd0;
            sym_tuser  <= 1'b0;
            sym_tlast  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_tvalid) begin
                        mode       <= cfg_is_bpsk;
                        pre_cnt    <= 5'd0;
                        byte_cnt   <= 8'd0;
                        sym_cnt    <= 3'd0;
                        sym_tvalid <= 1'b1;
                        sym_tdata  <= {6'b0, PRE_ALIGNED[31], 1'b0};
                        sym_tuser  <= 1'b1;
                        sym_tlast  <= 1'b0;
                        state      <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (handshake) begin
                        if (pre_cnt == PRE_LAST) begin
                            sym_tvalid <= 1'b0;
                            state      <= ST_LOAD;
                        end else begin
                            pre_cnt   <= pre_cnt + 5'd1;
                            sym_tdata <= {6'b0, PRE_ALIGNED[5'd30 - pre_cnt], 1'b0};
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_tvalid) begin
                        shreg    <= in_tdata;
                        byte_cnt <= byte_cnt + 8'd1;
                        state    <= ST_PAY;
                    end
                end
                default: begin
                    if (pay_present) begin
                        sym_tvalid <= 1'b1;
                        sym_tdata  <= {6'b0, pay_bits};
                        sym_tuser  <= mode;
                        sym_tlast  <= final_byte && (next_idx == last_idx);
                        sym_cnt    <= next_idx;
                        shreg      <= mode ? {shreg[6:0], 1'b0} : {shreg[5:0], 2'b00};
                    end else if (handshake) begin
                        sym_tvalid <= 1'b0;
                        sym_tlast  <= 1'b0;
                        state      <= final_byte ? ST_IDLE : ST_LOAD;
                    end
                end
            endcase
        end
    end

endmodule
